// File: rtl/demux1x4_buf_if.sv
// Handshake/data bundle for demux1x4_buf: one producer feeding four slot consumers.
interface demux1x4_buf_if #(
   parameter int N     = 32,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     Din;
   logic [1:0]       Ctrl;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [N-1:0]     A;
   logic [N-1:0]     B;
   logic [N-1:0]     C;
   logic [N-1:0]     D;
   logic [4*CNT_W-1:0] sent_cnt;

   // Producer + consumers side (drives the word and the per-slot ready bits)
   modport master (
      output in_valid, Din, Ctrl, out_ready,
      input  in_ready, out_valid, A, B, C, D, sent_cnt
   );

   // Demultiplexer side
   modport slave (
      input  in_valid, Din, Ctrl, out_ready,
      output in_ready, out_valid, A, B, C, D, sent_cnt
   );
endinterface

// File: rtl/demux1x4_buf.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake. Each slot has a
// one-entry holding register so a stalled consumer only blocks its own slot.
// Each slot also counts delivered words in a wrapping CNT_W-bit counter.
module demux1x4_buf #(
   parameter int N     = 32,
   parameter int CNT_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   demux1x4_buf_if.slave bus
);

   logic [3:0][N-1:0]     data;
   logic [3:0]            full;
   logic [3:0][CNT_W-1:0] cnt;
   logic                  ready;
   logic                  accept;
   logic [3:0]            load;
   logic [3:0]            consume;

   // Accept when the addressed slot is empty or is draining this same cycle
   always_comb begin
      ready   = ~full[bus.Ctrl] | bus.out_ready[bus.Ctrl];
      accept  = bus.in_valid & ready;
      load    = '0;
      if (accept) begin
         load[bus.Ctrl] = 1'b1;
      end
      consume = full & bus.out_ready;
   end

   // Slot registers and delivered-word counters; load wins over consume
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data <= '0;
         full <= '0;
         cnt  <= '0;
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (load[k]) begin
               data[k] <= bus.Din;
               full[k] <= 1'b1;
            end else if (consume[k]) begin
               full[k] <= 1'b0;
            end
            if (consume[k]) begin
               cnt[k] <= cnt[k] + 1'b1;
            end
         end
      end
   end

   // Drive interface outputs straight from the registers
   always_comb begin
      bus.in_ready  = ready;
      bus.out_valid = full;
      bus.A         = data[0];
      bus.B         = data[1];
      bus.C         = data[2];
      bus.D         = data[3];
      bus.sent_cnt  = cnt;
   end

endmodule

// File: tb/tb_demux1x4_buf.sv
// Self-checking bench for demux1x4_buf: per-slot occupancy model plus a
// delivery-order scoreboard for slot D, and directed literal checks.
module tb_demux1x4_buf;
   logic clk;
   logic rst_n;

   demux1x4_buf_if #(.N(32), .CNT_W(8)) bus ();

   demux1x4_buf #(.N(32), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Model: which slots are occupied, the word each slot shows, delivered counts
   bit          m_full [4];
   logic [31:0] m_word [4];
   int          m_sent [4];
   bit          m_live = 0;
   logic [31:0] d_queue [$];

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update at each rising edge from the spec's slot rules
   always @(posedge clk) begin
      bit cons [4];
      bit acc;
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            m_full[k] = 0;
            m_word[k] = 32'h0;
            m_sent[k] = 0;
         end
         d_queue.delete();
      end else begin
         for (int k = 0; k < 4; k++) cons[k] = m_full[k] && bus.out_ready[k];
         acc = bus.in_valid && (!m_full[bus.Ctrl] || bus.out_ready[bus.Ctrl]);
         for (int k = 0; k < 4; k++) begin
            if (cons[k]) begin
               m_full[k] = 0;
               m_sent[k] = (m_sent[k] + 1) % 256;
            end
         end
         if (acc) begin
            m_full[bus.Ctrl] = 1;
            m_word[bus.Ctrl] = bus.Din;
            if (bus.Ctrl == 2'd3) d_queue.push_back(bus.Din);
         end
      end
      m_live = 1;
   end

   // Compare process: every falling edge once the model has seen an edge
   always @(negedge clk) begin
      logic [31:0] exp_d;
      if (m_live) begin
         check("out_valid", bus.out_valid, {m_full[3], m_full[2], m_full[1], m_full[0]});
         check("A", bus.A, m_word[0]);
         check("B", bus.B, m_word[1]);
         check("C", bus.C, m_word[2]);
         check("D", bus.D, m_word[3]);
         check("sent_cnt", bus.sent_cnt, {m_sent[3][7:0], m_sent[2][7:0], m_sent[1][7:0], m_sent[0][7:0]});
         check("in_ready", bus.in_ready, !m_full[bus.Ctrl] || bus.out_ready[bus.Ctrl]);
         if (rst_n && bus.out_valid[3] && bus.out_ready[3]) begin
            if (d_queue.size() == 0) begin
               check("d_order_empty", 1, 0);
            end else begin
               exp_d = d_queue.pop_front();
               check("d_order", bus.D, exp_d);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 0;
      bus.in_valid  = 0;
      bus.out_ready = 4'b0000;
      tick();
      rst_n = 1;
   endtask

   initial begin
      // 1: reset held two edges with in_valid asserted
      rst_n         = 0;
      bus.in_valid  = 1;
      bus.Din       = 32'h1234_5678;
      bus.Ctrl      = 2'b00;
      bus.out_ready = 4'b0000;
      tick();
      tick();
      check("t1_out_valid", bus.out_valid, 4'b0000);
      check("t1_A", bus.A, 32'h0);
      check("t1_D", bus.D, 32'h0);
      check("t1_sent_cnt", bus.sent_cnt, 32'h0);
      rst_n        = 1;
      bus.in_valid = 0;
      tick();

      // 2: single word routed to C
      bus.Din      = 32'hDEAD_BEEF;
      bus.Ctrl     = 2'b10;
      bus.in_valid = 1;
      tick();
      bus.in_valid = 0;
      check("t2_out_valid", bus.out_valid, 4'b0100);
      check("t2_C", bus.C, 32'hDEAD_BEEF);
      check("t2_A", bus.A, 32'h0);
      tick();
      check("t2_hold_valid", bus.out_valid, 4'b0100);

      // 3: stalled B refuses, D still accepts
      do_reset();
      bus.Din      = 32'hB0B0_0001;
      bus.Ctrl     = 2'b01;
      bus.in_valid = 1;
      tick();
      bus.Din = 32'hB0B0_0002;
      #1;
      check("t3_ready_low", bus.in_ready, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_B_held", bus.B, 32'hB0B0_0001);
         check("t3_B_valid", bus.out_valid[1], 1'b1);
      end
      bus.Ctrl = 2'b11;
      bus.Din  = 32'hD00D_0001;
      #1;
      check("t3_ready_D", bus.in_ready, 1'b1);
      tick();
      bus.in_valid = 0;
      check("t3_out_valid", bus.out_valid, 4'b1010);
      check("t3_D", bus.D, 32'hD00D_0001);
      check("t3_B_final", bus.B, 32'hB0B0_0001);

      // 4: drain and refill A in the same cycle
      do_reset();
      bus.Din      = 32'h1;
      bus.Ctrl     = 2'b00;
      bus.in_valid = 1;
      tick();
      bus.Din       = 32'h2;
      bus.out_ready = 4'b0001;
      #1;
      check("t4_ready", bus.in_ready, 1'b1);
      tick();
      bus.in_valid  = 0;
      bus.out_ready = 4'b0000;
      check("t4_A", bus.A, 32'h2);
      check("t4_A_valid", bus.out_valid[0], 1'b1);
      check("t4_cnt_A", bus.sent_cnt[7:0], 8'd1);

      // 5: stream 260 words into D with the consumer always ready
      do_reset();
      bus.out_ready = 4'b1000;
      bus.Ctrl      = 2'b11;
      bus.in_valid  = 1;
      for (int i = 0; i < 260; i++) begin
         bus.Din = 32'hD000_0000 + i;
         #1;
         check("t5_ready", bus.in_ready, 1'b1);
         tick();
      end
      bus.in_valid = 0;
      tick();
      bus.out_ready = 4'b0000;
      check("t5_cnt_D", bus.sent_cnt[31:24], 8'd4);
      check("t5_D_last", bus.D, 32'hD000_0103);
      check("t5_D_empty", bus.out_valid[3], 1'b0);

      // 6: reset discards buffered A and C without counting them
      do_reset();
      bus.Din      = 32'hAAAA_0001;
      bus.Ctrl     = 2'b00;
      bus.in_valid = 1;
      tick();
      bus.Din  = 32'hCCCC_0001;
      bus.Ctrl = 2'b10;
      tick();
      bus.in_valid = 0;
      check("t6_filled", bus.out_valid, 4'b0101);
      rst_n         = 0;
      bus.out_ready = 4'b0101;
      tick();
      rst_n         = 1;
      bus.out_ready = 4'b0000;
      check("t6_out_valid", bus.out_valid, 4'b0000);
      check("t6_sent_cnt", bus.sent_cnt, 32'h0);
      tick();
      check("t6_still_clear", bus.out_valid, 4'b0000);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
